// File: rtl/oddr_tx_sequencer.sv
// oddr_tx_sequencer: serialises WIDTH-bit words MSB-first into bit pairs for one ODDR, and owns ODDR CE/R/S.
// Latency: word accepted at edge N is driven on D1/D2 after edge N+1; gapless at one word per WIDTH/2 cycles.
// Backpressure: DATA_READY = !hold_valid (single hold word, no bypass); ODDR_SEQ_UNDERRUN_CNT_EN adds UNDERRUN_CNT.
module oddr_tx_sequencer #(
    parameter int   WIDTH       = 8,
    parameter logic IDLE_LEVEL  = 1'b0,
    parameter int   RST_STRETCH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENABLE,
    input  logic             ABORT,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             DATA_LAST,
    input  logic             DATA_VALID,
    output logic             DATA_READY,
    output logic             ODDR_D1,
    output logic             ODDR_D2,
    output logic             ODDR_CE,
    output logic             ODDR_R,
    output logic             ODDR_S,
    output logic             BUSY,
    output logic             DONE,
    output logic             UNDERRUN
`ifdef ODDR_SEQ_UNDERRUN_CNT_EN
    ,
    output logic [7:0]       UNDERRUN_CNT
`endif
);

    localparam int NPAIRS = WIDTH / 2;
    localparam int CNT_W  = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
    localparam int RC_W   = (RST_STRETCH > 1) ? $clog2(RST_STRETCH + 1) : 1;
    localparam logic [CNT_W-1:0] PAIR_LAST = CNT_W'(NPAIRS - 1);
    localparam logic [RC_W-1:0]  RC_INIT   = RC_W'(RST_STRETCH);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hold_dat_q, hold_dat_d;
    logic               hold_last_q, hold_last_d;
    logic               hold_vld_q, hold_vld_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               sh_last_q, sh_last_d;
    logic [CNT_W-1:0]   pair_cnt_q, pair_cnt_d;
    logic               done_q, done_d;
    logic               underrun_q, underrun_d;
    logic [RC_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic               transfer;

    assign transfer = DATA_VALID && !hold_vld_q && ENABLE && !ABORT;

    always_comb begin
        state_d     = state_q;
        hold_dat_d  = hold_dat_q;
        hold_last_d = hold_last_q;
        hold_vld_d  = hold_vld_q;
        sh_d        = sh_q;
        sh_last_d   = sh_last_q;
        pair_cnt_d  = pair_cnt_q;
        done_d      = 1'b0;
        underrun_d  = 1'b0;
        if (ABORT) begin
            state_d    = S_IDLE;
            hold_vld_d = 1'b0;
            sh_d       = '0;
            sh_last_d  = 1'b0;
            pair_cnt_d = '0;
        end else if (ENABLE) begin
            // transfer needs an empty hold and draining needs a full one, so they never collide
            if (transfer) begin
                hold_dat_d  = DATA_IN;
                hold_last_d = DATA_LAST;
                hold_vld_d  = 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (hold_vld_q) begin
                        sh_d       = hold_dat_q;
                        sh_last_d  = hold_last_q;
                        pair_cnt_d = '0;
                        hold_vld_d = 1'b0;
                        state_d    = S_RUN;
                    end
                end
                S_RUN: begin
                    sh_d       = sh_q << 2;
                    pair_cnt_d = pair_cnt_q + CNT_W'(1);
                    if (pair_cnt_q == PAIR_LAST) begin
                        pair_cnt_d = '0;
                        if (hold_vld_q) begin
                            sh_d       = hold_dat_q;
                            sh_last_d  = hold_last_q;
                            hold_vld_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            if (sh_last_q) done_d     = 1'b1;
                            else           underrun_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rst_cnt_d = rst_cnt_q;
        if (rst_cnt_q != '0) rst_cnt_d = rst_cnt_q - RC_W'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            hold_dat_q  <= '0;
            hold_last_q <= 1'b0;
            hold_vld_q  <= 1'b0;
            sh_q        <= '0;
            sh_last_q   <= 1'b0;
            pair_cnt_q  <= '0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            rst_cnt_q   <= RC_INIT;
        end else begin
            state_q     <= state_d;
            hold_dat_q  <= hold_dat_d;
            hold_last_q <= hold_last_d;
            hold_vld_q  <= hold_vld_d;
            sh_q        <= sh_d;
            sh_last_q   <= sh_last_d;
            pair_cnt_q  <= pair_cnt_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
            rst_cnt_q   <= rst_cnt_d;
        end
    end

`ifdef ODDR_SEQ_UNDERRUN_CNT_EN
    logic [7:0] underrun_cnt_q, underrun_cnt_d;

    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        if (ABORT)                                      underrun_cnt_d = '0;
        else if (underrun_d && underrun_cnt_q != 8'hFF) underrun_cnt_d = underrun_cnt_q + 8'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) underrun_cnt_q <= '0;
        else     underrun_cnt_q <= underrun_cnt_d;
    end

    assign UNDERRUN_CNT = underrun_cnt_q;
`endif

    assign DATA_READY = !hold_vld_q;
    assign ODDR_D1    = (state_q == S_RUN) ? sh_q[WIDTH-1] : IDLE_LEVEL;
    assign ODDR_D2    = (state_q == S_RUN) ? sh_q[WIDTH-2] : IDLE_LEVEL;
    assign ODDR_CE    = ENABLE;
    assign ODDR_R     = RST || (rst_cnt_q != '0);
    assign ODDR_S     = 1'b0;
    assign BUSY       = (state_q == S_RUN) || hold_vld_q;
    assign DONE       = done_q;
    assign UNDERRUN   = underrun_q;

endmodule

// File: tb/tb_oddr_tx_sequencer.sv
// Bench for oddr_tx_sequencer (WIDTH=8): directed scenarios with literal pins plus randomized traffic
// checked every cycle against a word-queue model of the sequencer.
module tb_oddr_tx_sequencer;

    localparam int W  = 8;
    localparam int NP = W / 2;
    localparam int RS = 2;

    logic         CLK = 1'b0;
    logic         RST, ENABLE, ABORT, DATA_LAST, DATA_VALID;
    logic [W-1:0] DATA_IN;
    logic         DATA_READY, ODDR_D1, ODDR_D2, ODDR_CE, ODDR_R, ODDR_S, BUSY, DONE, UNDERRUN;

    int n_tests = 0;
    int n_fail  = 0;

    oddr_tx_sequencer #(.WIDTH(W), .IDLE_LEVEL(1'b0), .RST_STRETCH(RS)) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .ABORT(ABORT),
        .DATA_IN(DATA_IN), .DATA_LAST(DATA_LAST), .DATA_VALID(DATA_VALID),
        .DATA_READY(DATA_READY), .ODDR_D1(ODDR_D1), .ODDR_D2(ODDR_D2),
        .ODDR_CE(ODDR_CE), .ODDR_R(ODDR_R), .ODDR_S(ODDR_S),
        .BUSY(BUSY), .DONE(DONE), .UNDERRUN(UNDERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: the word being serialised (with count of pairs already shown) and one waiting word.
    logic         m_cur_v, m_cur_last, m_wait_v, m_wait_last, m_done, m_und;
    logic [W-1:0] m_cur_w, m_wait_w;
    int           m_idx, m_rcnt;

    task automatic model_take_wait();
        m_cur_v    = 1'b1;
        m_cur_w    = m_wait_w;
        m_cur_last = m_wait_last;
        m_idx      = 0;
        m_wait_v   = 1'b0;
    endtask

    // Inputs change only at negedge+2, so at a negedge they are exactly what the preceding posedge saw.
    task automatic model_step();
        logic acc;
        if (RST) begin
            m_cur_v = 1'b0; m_wait_v = 1'b0; m_idx = 0;
            m_done = 1'b0; m_und = 1'b0; m_rcnt = RS;
            return;
        end
        if (m_rcnt > 0) m_rcnt--;
        m_done = 1'b0;
        m_und  = 1'b0;
        if (ABORT) begin
            m_cur_v  = 1'b0;
            m_wait_v = 1'b0;
        end else if (ENABLE) begin
            acc = DATA_VALID && !m_wait_v;
            if (m_cur_v) begin
                m_idx++;
                if (m_idx == NP) begin
                    m_cur_v = 1'b0;
                    if (m_wait_v)        model_take_wait();
                    else if (m_cur_last) m_done = 1'b1;
                    else                 m_und  = 1'b1;
                end
            end else if (m_wait_v) begin
                model_take_wait();
            end
            if (acc) begin
                m_wait_v    = 1'b1;
                m_wait_w    = DATA_IN;
                m_wait_last = DATA_LAST;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            model_step();
            chk("cyc_d1",    ODDR_D1,    m_cur_v ? m_cur_w[W-1-2*m_idx] : 1'b0);
            chk("cyc_d2",    ODDR_D2,    m_cur_v ? m_cur_w[W-2-2*m_idx] : 1'b0);
            chk("cyc_ready", DATA_READY, !m_wait_v);
            chk("cyc_busy",  BUSY,       m_cur_v || m_wait_v);
            chk("cyc_done",  DONE,       m_done);
            chk("cyc_und",   UNDERRUN,   m_und);
            chk("cyc_ce",    ODDR_CE,    ENABLE);
            chk("cyc_r",     ODDR_R,     RST || (m_rcnt > 0));
            chk("cyc_s",     ODDR_S,     1'b0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge CLK);
        #2;
    endtask

    task automatic send_one(input logic [W-1:0] w, input logic last);
        DATA_VALID = 1'b1; DATA_IN = w; DATA_LAST = last;
        tick();
        DATA_VALID = 1'b0;
    endtask

    task automatic chk_pairs(input string nm, input logic [7:0] seq);
        for (int i = 0; i < NP; i++) begin
            tick();
            chk(nm, {ODDR_D1, ODDR_D2}, 8'(seq[7-2*i -: 2]));
        end
    endtask

    initial begin
        logic [1:0] obs_pair [12];
        logic       obs_busy [12];
        logic       obs_done [12];
        int         done_cnt, und_cnt;
        logic       acc;

        RST = 1'b1; ENABLE = 1'b1; ABORT = 1'b0;
        DATA_VALID = 1'b0; DATA_LAST = 1'b0; DATA_IN = '0;
        tick(); tick();
        chk("rst_ready", DATA_READY, 1'b1);
        chk("rst_busy",  BUSY, 1'b0);
        chk("rst_d",     {ODDR_D1, ODDR_D2}, 8'h0);
        chk("rst_r",     ODDR_R, 1'b1);
        chk("rst_pulse", {DONE, UNDERRUN}, 8'h0);
        RST = 1'b0;
        #1 chk("rst_rel0", ODDR_R, 1'b1);
        tick(); chk("rst_rel1", ODDR_R, 1'b1);
        tick(); chk("rst_rel2", ODDR_R, 1'b0);

        // single LAST word: first pair one edge after accept, DONE right after the 4th pair
        send_one(8'hB4, 1'b1);
        chk("b4_wait", {ODDR_D1, ODDR_D2}, 8'h0);
        chk("b4_busy", BUSY, 1'b1);
        chk_pairs("b4_pair", 8'b10_11_01_00);
        tick();
        chk("b4_done", DONE, 1'b1);
        chk("b4_idle", {ODDR_D1, ODDR_D2, BUSY}, 8'h0);

        // back-to-back FF then 00(LAST) with VALID held until accepted
        DATA_VALID = 1'b1; DATA_IN = 8'hFF; DATA_LAST = 1'b0;
        done_cnt = 0; und_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            acc = DATA_VALID && DATA_READY;
            tick();
            if (acc) begin
                if (DATA_IN == 8'hFF) begin DATA_IN = 8'h00; DATA_LAST = 1'b1; end
                else DATA_VALID = 1'b0;
            end
            obs_pair[i] = {ODDR_D1, ODDR_D2};
            obs_busy[i] = BUSY;
            obs_done[i] = DONE;
            done_cnt += int'(DONE);
            und_cnt  += int'(UNDERRUN);
        end
        for (int i = 1; i <= 8; i++) begin
            chk("b2b_pair", 8'(obs_pair[i]), (i <= 4) ? 8'h3 : 8'h0);
            chk("b2b_busy", 8'(obs_busy[i]), 8'h1);
        end
        chk("b2b_done_at", 8'(obs_done[9]), 8'h1);
        chk("b2b_done_cnt", 8'(done_cnt), 8'd1);
        chk("b2b_und_cnt",  8'(und_cnt),  8'd0);

        // word without LAST and no follow-up
        send_one(8'hC3, 1'b0);
        chk_pairs("c3_pair", 8'b11_00_00_11);
        tick();
        chk("c3_und",  UNDERRUN, 1'b1);
        chk("c3_done", DONE, 1'b0);
        chk("c3_d",    {ODDR_D1, ODDR_D2}, 8'h0);

        // ENABLE low for 3 cycles mid-word
        send_one(8'hB4, 1'b1);
        tick(); chk("en_p0", {ODDR_D1, ODDR_D2}, 8'h2);
        tick(); chk("en_p1", {ODDR_D1, ODDR_D2}, 8'h3);
        ENABLE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en_frozen", {ODDR_D1, ODDR_D2}, 8'h3);
            chk("en_ce", ODDR_CE, 1'b0);
        end
        ENABLE = 1'b1;
        tick(); chk("en_p2", {ODDR_D1, ODDR_D2}, 8'h1);
        tick(); chk("en_p3", {ODDR_D1, ODDR_D2}, 8'h0);
        tick(); chk("en_done", DONE, 1'b1);

        // ABORT on pair 2 while a second word sits in the hold register
        send_one(8'hF0, 1'b0);
        DATA_VALID = 1'b1; DATA_IN = 8'hAA; DATA_LAST = 1'b1;
        tick(); chk("ab_p0", {ODDR_D1, ODDR_D2}, 8'h3);
        tick(); chk("ab_p1", {ODDR_D1, ODDR_D2}, 8'h3);
        DATA_VALID = 1'b0;
        chk("ab_held", DATA_READY, 1'b0);
        tick(); chk("ab_p2", {ODDR_D1, ODDR_D2}, 8'h0);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("ab_ready", DATA_READY, 1'b1);
        chk("ab_busy",  BUSY, 1'b0);
        chk("ab_pulse", {DONE, UNDERRUN}, 8'h0);
        tick();
        chk("ab_pulse2", {DONE, UNDERRUN, ODDR_D1, ODDR_D2}, 8'h0);

        // RST mid-burst
        send_one(8'hFF, 1'b1);
        tick(); tick();
        RST = 1'b1;
        #1;
        chk("mrst_d",     {ODDR_D1, ODDR_D2}, 8'h0);
        chk("mrst_ready", DATA_READY, 1'b1);
        chk("mrst_busy",  BUSY, 1'b0);
        chk("mrst_r",     ODDR_R, 1'b1);
        tick();
        RST = 1'b0;
        #1 chk("mrst_rel0", ODDR_R, 1'b1);
        tick(); chk("mrst_rel1", ODDR_R, 1'b1);
        tick(); chk("mrst_rel2", ODDR_R, 1'b0);
        chk("mrst_lost", {BUSY, DONE, UNDERRUN}, 8'h0);

        // randomized traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            RST        = ($urandom_range(0, 249) == 0);
            ABORT      = ($urandom_range(0, 39) == 0);
            ENABLE     = ($urandom_range(0, 9) != 0);
            DATA_VALID = ($urandom_range(0, 9) < 7);
            DATA_IN    = W'($urandom);
            DATA_LAST  = ($urandom_range(0, 3) == 0);
            tick();
        end
        RST = 1'b0; ABORT = 1'b0; ENABLE = 1'b1; DATA_VALID = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
